// File: rtl/decoder_sched_pkg.sv
// Shared types and constants for the decoder scheduler.
//   state_t   : scheduler FSM encoding
//   DEC_IN_W  : input width of the shared decoder core
//   *_RST     : reset values of the scheduler registers
package decoder_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int DEC_IN_W = 7;

  localparam state_t STATE_RST = S_IDLE;
  localparam logic   BIT_RST   = 1'b0;

endpackage

// File: rtl/decoder_sched_rr_pick.sv
// Combinational rotating-priority encoder.
//   req    : request vector
//   rr_ptr : index holding highest priority this round
//   win_id : first requester at or after rr_ptr (wrapping)
//   any    : at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] win_id,
  output logic             any
);

  // Scan from the farthest offset down to rr_ptr so the nearest
  // asserted requester is the last (winning) assignment.
  always_comb begin
    int j;
    j      = 0;
    win_id = '0;
    any    = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        win_id = PTR_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_sched.sv
// Round-robin scheduler sharing one combinational decoder core.
//   clock, reset : rising-edge clock, async active-high reset
//   req, code    : per-requester level request and packed input codes
//   ack          : one-hot one-cycle completion pulse
//   result       : captured decoder output (held between grants)
//   grant_id     : current / last granted requester
//   busy         : FSM not idle
//   dec_in       : registered drive to the decoder core
//   dec_out      : decoder core output
//
// state  | meaning
// S_IDLE | waiting for any req; picks winner from rr_ptr
// S_HOLD | dec_in held while cnt counts down to 0
// S_ACK  | ack/result valid for this single cycle
module decoder_sched
  import decoder_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IN_W  = 7,
  parameter int OUT_W = 8,
  parameter int HOLD  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*IN_W-1:0]    code,
  output logic [N_REQ-1:0]         ack,
  output logic [OUT_W-1:0]         result,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [IN_W-1:0]          dec_in,
  input  logic [OUT_W-1:0]         dec_out
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD + 1);

  if (HOLD < 1) begin : g_bad_hold
    $error("decoder_sched: HOLD must be at least 1");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("decoder_sched: N_REQ must be in 2..8");
  end
  if (IN_W != DEC_IN_W) begin : g_bad_inw
    $error("decoder_sched: IN_W must match the decoder core input width");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_id_q, grant_id_d;
  logic [IN_W-1:0]  dec_in_q, dec_in_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [PTR_W-1:0] win_id;
  logic             any_req;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .win_id (win_id),
    .any    (any_req)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    dec_in_d   = dec_in_q;
    result_d   = result_q;
    ack_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_id_d = win_id;
          dec_in_d   = code[int'(win_id)*IN_W +: IN_W];
          cnt_d      = CNT_W'(HOLD - 1);
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d          = dec_out;
          ack_d[grant_id_q] = 1'b1;
          // Explicit wrap keeps non-power-of-2 N_REQ in range.
          rr_ptr_d = (grant_id_q == PTR_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= STATE_RST;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      dec_in_q   <= '0;
      result_q   <= '0;
      ack_q      <= {N_REQ{BIT_RST}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      dec_in_q   <= dec_in_d;
      result_q   <= result_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign result   = result_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != S_IDLE);
  assign dec_in   = dec_in_q;

endmodule

// File: tb/tb_decoder_sched.sv
module tb_decoder_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [27:0] code  = '0;
  logic [3:0]  ack;
  logic [7:0]  result;
  logic [1:0]  grant_id;
  logic        busy;
  logic [6:0]  dec_in;
  logic [7:0]  dec_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Stand-in for the decoder core.
  function automatic logic [7:0] dec_model(input logic [6:0] x);
    if (x == 7'b1111011) return 8'hA5;
    return {1'b0, x} ^ 8'h5A;
  endfunction

  assign dec_out = dec_model(dec_in);

  decoder_sched #(.N_REQ(4), .IN_W(7), .OUT_W(8), .HOLD(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .code     (code),
    .ack      (ack),
    .result   (result),
    .grant_id (grant_id),
    .busy     (busy),
    .dec_in   (dec_in),
    .dec_out  (dec_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [27:0] code;
    logic [1:0]  id;
    logic [6:0]  din;
    logic [7:0]  res;
  } vec_t;

  vec_t vecs[8];

  localparam logic [27:0] CODE_DEF = {7'h60, 7'h05, 7'h7B, 7'h12};

  // One complete transaction: req raised in IDLE cycle t.
  task automatic run_txn(input int k, input vec_t v);
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << v.id;
    req  = v.req;
    code = v.code;
    step();  // t+1
    chk($sformatf("v%0d dec_in", k), 32'(dec_in), 32'(v.din));
    chk($sformatf("v%0d busy_t1", k), 32'(busy), 32'd1);
    chk($sformatf("v%0d ack_t1", k), 32'(ack), 32'd0);
    step();  // t+2
    step();  // t+3
    chk($sformatf("v%0d ack", k), 32'(ack), 32'(exp_ack));
    chk($sformatf("v%0d result", k), 32'(result), 32'(v.res));
    chk($sformatf("v%0d grant_id", k), 32'(grant_id), 32'(v.id));
    step();  // t+4
    req = '0;
    chk($sformatf("v%0d ack_t4", k), 32'(ack), 32'd0);
    chk($sformatf("v%0d busy_t4", k), 32'(busy), 32'd0);
    chk($sformatf("v%0d result_hold", k), 32'(result), 32'(v.res));
  endtask

  initial begin
    int nack;
    int last_cyc;
    logic [3:0] exp_ack;

    // rr_ptr sequence after reset: 0 ->2 ->0 ->1 ->3 ->0 ->1 ->2 ->1
    vecs[0] = '{4'b0010, CODE_DEF, 2'd1, 7'h7B, 8'hA5};
    vecs[1] = '{4'b1001, CODE_DEF, 2'd3, 7'h60, 8'h3A};
    vecs[2] = '{4'b0101, CODE_DEF, 2'd0, 7'h12, 8'h48};
    vecs[3] = '{4'b0101, CODE_DEF, 2'd2, 7'h05, 8'h5F};
    vecs[4] = '{4'b1001, CODE_DEF, 2'd3, 7'h60, 8'h3A};
    vecs[5] = '{4'b1001, {7'h60, 7'h05, 7'h7B, 7'h2A}, 2'd0, 7'h2A, 8'h70};
    vecs[6] = '{4'b0011, CODE_DEF, 2'd1, 7'h7B, 8'hA5};
    vecs[7] = '{4'b0001, {7'h60, 7'h05, 7'h7B, 7'h7F}, 2'd0, 7'h7F, 8'h25};

    // Reset and idle
    step();
    step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle dec_in", 32'(dec_in), 32'd0);
      chk("idle ack", 32'(ack), 32'd0);
    end

    // All requesters continuously: 0,1,2,3,0 spaced 4 cycles
    req  = 4'b1111;
    code = CODE_DEF;
    nack = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && nack < 5; cyc++) begin
      step();
      if (ack != 4'b0000) begin
        exp_ack = 4'b0001 << (nack % 4);
        chk($sformatf("rr ack %0d", nack), 32'(ack), 32'(exp_ack));
        chk($sformatf("rr grant_id %0d", nack), 32'(grant_id), 32'(nack % 4));
        if (nack > 0) chk($sformatf("rr spacing %0d", nack), 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        nack++;
      end
    end
    chk("rr ack count", 32'(nack), 32'd5);
    req = '0;
    for (int i = 0; i < 10 && busy; i++) step();
    chk("rr drained", 32'(busy), 32'd0);

    // Fresh reset so the table starts with rr_ptr = 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    for (int k = 0; k < 8; k++) run_txn(k, vecs[k]);

    // Code changes during HOLD must not reach dec_in
    req  = 4'b0001;
    code = {7'h60, 7'h05, 7'h7B, 7'h12};
    step();  // t+1
    code = {7'h60, 7'h05, 7'h7B, 7'h34};
    chk("chg dec_in t1", 32'(dec_in), 32'h12);
    step();  // t+2
    chk("chg dec_in t2", 32'(dec_in), 32'h12);
    step();  // t+3
    chk("chg ack", 32'(ack), 32'b0001);
    chk("chg result", 32'(result), 32'h48);
    step();
    req = '0;

    // Reset asserted during HOLD
    req  = 4'b0100;
    code = CODE_DEF;
    step();  // HOLD
    chk("rh busy pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rh busy", 32'(busy), 32'd0);
    chk("rh dec_in", 32'(dec_in), 32'd0);
    chk("rh result", 32'(result), 32'd0);
    chk("rh grant_id", 32'(grant_id), 32'd0);
    chk("rh ack", 32'(ack), 32'd0);
    step();
    chk("rh ack held", 32'(ack), 32'd0);
    step();
    chk("rh ack held2", 32'(ack), 32'd0);
    reset = 1'b0;
    step();
    chk("rh regrant id", 32'(grant_id), 32'd2);
    chk("rh regrant dec_in", 32'(dec_in), 32'h05);
    chk("rh regrant busy", 32'(busy), 32'd1);
    step();
    step();
    chk("rh ack", 32'(ack), 32'b0100);
    chk("rh result after", 32'(result), 32'h5F);
    step();
    req = '0;
    chk("rh ack end", 32'(ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
